// File: rtl/pll_reconfig_seq.sv
// Drives a fixed four-beat Avalon-MM write sequence into a PLL reconfig block to switch
// between NTSC and PAL presets, then tracks the PLL through unlock and relock.
module pll_reconfig_seq #(
  parameter logic [31:0] M_NTSC       = 32'h0000_0C0C,
  parameter logic [31:0] K_NTSC       = 32'd234263494,
  parameter logic [31:0] M_PAL        = 32'h0000_0B0B,
  parameter logic [31:0] K_PAL        = 32'd3149642683,
  parameter logic [23:0] LOCK_TIMEOUT = 24'd1000000,
  parameter logic [7:0]  UNLOCK_WAIT  = 8'd255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        sel,
  input  logic        pll_locked,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic [31:0] mgmt_writedata,
  input  logic        mgmt_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        cur_sel
);

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 24;
  localparam int unsigned IDX_W  = 2;

  localparam logic [2:0] IDLE        = 3'd0;
  localparam logic [2:0] WR          = 3'd1;
  localparam logic [2:0] WAIT_UNLOCK = 3'd2;
  localparam logic [2:0] WAIT_LOCK   = 3'd3;
  localparam logic [2:0] FIN         = 3'd4;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(3);

  logic [2:0]        state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt, cnt_inc;
  logic              sel_q, sel_q_nxt;
  logic              lk_seen, lk_seen_nxt;
  logic [1:0]        sync;
  logic              lk;
  logic              beat_done;

  logic              wr_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic              busy_nxt;
  logic              done_nxt;
  logic              err_nxt;
  logic              cur_sel_nxt;

  // Reconfig register map for each beat of the sequence
  function automatic logic [ADDR_W-1:0] beat_addr(input logic [IDX_W-1:0] i);
    case (i)
      2'd0:    beat_addr = ADDR_W'(6'h00);
      2'd1:    beat_addr = ADDR_W'(6'h04);
      2'd2:    beat_addr = ADDR_W'(6'h07);
      default: beat_addr = ADDR_W'(6'h02);
    endcase
  endfunction

  // Beat 0 selects waitrequest mode and beat 3 is the start trigger; both write zero
  function automatic logic [DATA_W-1:0] beat_data(input logic [IDX_W-1:0] i, input logic s);
    case (i)
      2'd1:    beat_data = s ? M_PAL : M_NTSC;
      2'd2:    beat_data = s ? K_PAL : K_NTSC;
      default: beat_data = '0;
    endcase
  endfunction

  assign lk        = sync[1];
  assign beat_done = mgmt_write & ~mgmt_waitrequest;
  assign cnt_inc   = cnt + CNT_W'(1);

  // pll_locked is asynchronous to clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b00;
    else        sync <= {sync[0], pll_locked};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      idx            <= '0;
      cnt            <= '0;
      sel_q          <= 1'b0;
      lk_seen        <= 1'b0;
      mgmt_write     <= 1'b0;
      mgmt_address   <= '0;
      mgmt_writedata <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      cur_sel        <= 1'b0;
    end else begin
      state          <= state_nxt;
      idx            <= idx_nxt;
      cnt            <= cnt_nxt;
      sel_q          <= sel_q_nxt;
      lk_seen        <= lk_seen_nxt;
      mgmt_write     <= wr_nxt;
      mgmt_address   <= addr_nxt;
      mgmt_writedata <= data_nxt;
      busy           <= busy_nxt;
      done           <= done_nxt;
      err            <= err_nxt;
      cur_sel        <= cur_sel_nxt;
    end
  end

  // Next state and next registered outputs
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    cnt_nxt     = cnt;
    sel_q_nxt   = sel_q;
    lk_seen_nxt = lk_seen;
    wr_nxt      = mgmt_write;
    addr_nxt    = mgmt_address;
    data_nxt    = mgmt_writedata;
    err_nxt     = err;
    cur_sel_nxt = cur_sel;

    case (state)
      IDLE: begin
        if (req) begin
          state_nxt = WR;
          sel_q_nxt = sel;
          err_nxt   = 1'b0;
          idx_nxt   = '0;
          cnt_nxt   = '0;
          wr_nxt    = 1'b1;
          addr_nxt  = beat_addr('0);
          data_nxt  = beat_data('0, sel);
        end
      end

      WR: begin
        // Outputs simply hold while the slave stalls
        if (beat_done) begin
          if (idx != LAST_IDX) begin
            idx_nxt  = idx + IDX_W'(1);
            addr_nxt = beat_addr(idx + IDX_W'(1));
            data_nxt = beat_data(idx + IDX_W'(1), sel_q);
          end else begin
            wr_nxt    = 1'b0;
            addr_nxt  = '0;
            data_nxt  = '0;
            cnt_nxt   = '0;
            state_nxt = WAIT_UNLOCK;
          end
        end
      end

      WAIT_UNLOCK: begin
        // A PLL that never visibly unlocks is still given the chance to relock
        if (!lk || (cnt_inc >= CNT_W'(UNLOCK_WAIT))) begin
          state_nxt   = WAIT_LOCK;
          cnt_nxt     = '0;
          lk_seen_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end

      WAIT_LOCK: begin
        if (lk && lk_seen) begin
          state_nxt   = FIN;
          cnt_nxt     = '0;
          cur_sel_nxt = sel_q;
        end else if (cnt_inc >= LOCK_TIMEOUT) begin
          state_nxt = FIN;
          cnt_nxt   = '0;
          err_nxt   = 1'b1;
        end else begin
          cnt_nxt     = cnt_inc;
          lk_seen_nxt = lk;
        end
      end

      FIN: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end

      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
        cnt_nxt   = '0;
        wr_nxt    = 1'b0;
        addr_nxt  = '0;
        data_nxt  = '0;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == FIN);
  end

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Directed bench for pll_reconfig_seq: a transaction-level scoreboard of expected beats and
// sequence outcomes, checked every cycle, plus hand-computed timing literals per scenario.
module tb_pll_reconfig_seq;

  localparam logic [31:0] M_NTSC = 32'h0000_0C0C;
  localparam logic [31:0] K_NTSC = 32'd234263494;
  localparam logic [31:0] M_PAL  = 32'h0000_0B0B;
  localparam logic [31:0] K_PAL  = 32'd3149642683;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        sel;
  logic        pll_locked;
  logic [5:0]  mgmt_address;
  logic        mgmt_write;
  logic [31:0] mgmt_writedata;
  logic        mgmt_waitrequest;
  logic        busy;
  logic        done;
  logic        err;
  logic        cur_sel;

  pll_reconfig_seq #(
    .LOCK_TIMEOUT(24'd100)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req              (req),
    .sel              (sel),
    .pll_locked       (pll_locked),
    .mgmt_address     (mgmt_address),
    .mgmt_write       (mgmt_write),
    .mgmt_writedata   (mgmt_writedata),
    .mgmt_waitrequest (mgmt_waitrequest),
    .busy             (busy),
    .done             (done),
    .err              (err),
    .cur_sel          (cur_sel)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Scoreboard state
  logic [37:0] exp_beats[$];
  logic        exp_sel_q[$];
  logic        exp_err_q[$];
  logic        model_cur = 1'b0;
  logic        model_err = 1'b0;
  logic        tb_idle   = 1'b0;

  // Observations
  int          beat_cnt = 0;
  int          done_cnt = 0;
  int          start_cnt = 0;
  int          first_cyc = 0;
  int          start_cyc = 0;
  int          done_cyc = 0;
  int          k07_cycles = 0;
  logic [31:0] m_seen = '0;
  logic [31:0] k_seen = '0;
  logic        prev_done = 1'b0;
  logic        hold_pending = 1'b0;
  logic [5:0]  hold_a;
  logic [31:0] hold_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Compare process: outputs are stable at the falling edge
  always @(negedge clk) begin
    logic [37:0] b;
    logic        s, e;
    if (rst_n) begin
      if (hold_pending) begin
        chk("hold_write", 32'(mgmt_write), 32'd1);
        chk("hold_addr", 32'(mgmt_address), 32'(hold_a));
        chk("hold_data", mgmt_writedata, hold_d);
      end
      hold_pending = 1'b0;
      if (!mgmt_write) begin
        chk("idle_addr_zero", 32'(mgmt_address), 32'd0);
        chk("idle_data_zero", mgmt_writedata, 32'd0);
      end else if (mgmt_waitrequest) begin
        hold_pending = 1'b1;
        hold_a = mgmt_address;
        hold_d = mgmt_writedata;
      end else begin
        beat_cnt++;
        if (exp_beats.size() == 0) begin
          fail_now("unexpected_beat");
        end else begin
          b = exp_beats.pop_front();
          chk("beat_addr", 32'(mgmt_address), 32'(b[37:32]));
          chk("beat_data", mgmt_writedata, b[31:0]);
        end
        if (mgmt_address == 6'h00) first_cyc = cyc;
        if (mgmt_address == 6'h04) m_seen = mgmt_writedata;
        if (mgmt_address == 6'h07) k_seen = mgmt_writedata;
        if (mgmt_address == 6'h02) begin
          start_cyc = cyc;
          start_cnt++;
        end
      end
      if (mgmt_write && mgmt_address == 6'h07) k07_cycles++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_single_pulse", 32'(prev_done), 32'd0);
        chk("busy_at_done", 32'(busy), 32'd1);
        if (exp_sel_q.size() == 0) begin
          fail_now("unexpected_done");
        end else begin
          s = exp_sel_q.pop_front();
          e = exp_err_q.pop_front();
          chk("err_at_done", 32'(err), 32'(e));
          model_err = e;
          if (!e) model_cur = s;
        end
      end
      if (tb_idle) begin
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_err", 32'(err), 32'(model_err));
        chk("idle_cur_sel", 32'(cur_sel), 32'(model_cur));
      end
    end else begin
      hold_pending = 1'b0;
    end
    prev_done = done;
  end

  task automatic push_seq(input logic s, input logic will_timeout);
    exp_beats.push_back({6'h00, 32'd0});
    exp_beats.push_back({6'h04, s ? M_PAL : M_NTSC});
    exp_beats.push_back({6'h07, s ? K_PAL : K_NTSC});
    exp_beats.push_back({6'h02, 32'd0});
    exp_sel_q.push_back(s);
    exp_err_q.push_back(will_timeout);
  endtask

  // Accepted request; sel is scrambled right after capture
  task automatic send_req(input logic s, input logic will_timeout);
    @(posedge clk); #2;
    tb_idle = 1'b0;
    req = 1'b1;
    sel = s;
    push_seq(s, will_timeout);
    model_err = 1'b0;
    @(posedge clk); #2;
    req = 1'b0;
    sel = ~s;
  endtask

  task automatic pulse_req();
    @(posedge clk); #2;
    req = 1'b1;
    sel = 1'b0;
    @(posedge clk); #2;
    req = 1'b0;
  endtask

  task automatic wait_start(input int limit);
    int s0 = start_cnt;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk);
      if (start_cnt != s0) break;
    end
    chk("start_beat_seen", 32'(start_cnt - s0), 32'd1);
  endtask

  task automatic wait_done(input int limit);
    int d0 = done_cnt;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk);
      if (done_cnt != d0) break;
    end
    chk("done_seen", 32'(done_cnt - d0), 32'd1);
    #2;
    tb_idle = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    rst_n = 1'b0;
    req = 1'b0;
    sel = 1'b0;
    pll_locked = 1'b1;
    mgmt_waitrequest = 1'b0;
    #1;
    chk("rst_write", 32'(mgmt_write), 32'd0);
    chk("rst_addr", 32'(mgmt_address), 32'd0);
    chk("rst_data", mgmt_writedata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_cur_sel", 32'(cur_sel), 32'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    tb_idle = 1'b1;
    repeat (4) @(posedge clk);

    // NTSC, lock drops 3 cycles after start and returns 20 cycles later
    b0 = beat_cnt;
    send_req(1'b0, 1'b0);
    wait_start(20);
    repeat (3) @(posedge clk);
    #2 pll_locked = 1'b0;
    repeat (20) @(posedge clk);
    #2 pll_locked = 1'b1;
    wait_done(400);
    @(negedge clk);
    chk("ntsc_beats_consecutive", 32'(start_cyc - first_cyc), 32'd3);
    chk("ntsc_beat_count", 32'(beat_cnt - b0), 32'd4);
    chk("ntsc_m_word", m_seen, 32'h0000_0C0C);
    chk("ntsc_k_word", k_seen, 32'd234263494);
    chk("ntsc_err", 32'(err), 32'd0);
    chk("ntsc_cur_sel", 32'(cur_sel), 32'd0);

    // Slave stalls beat 2 for 5 cycles
    b0 = beat_cnt;
    k07_cycles = 0;
    send_req(1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk); #2;
    mgmt_waitrequest = 1'b1;
    repeat (5) @(posedge clk);
    #2 mgmt_waitrequest = 1'b0;
    wait_start(30);
    wait_done(400);
    @(negedge clk);
    chk("stall_k_held_cycles", 32'(k07_cycles), 32'd6);
    chk("stall_start_offset", 32'(start_cyc - first_cyc), 32'd8);
    chk("stall_beat_count", 32'(beat_cnt - b0), 32'd4);

    // PAL, lock never drops: 255 cycles unlock wait, 2 lock cycles, then FIN
    send_req(1'b1, 1'b0);
    wait_start(20);
    wait_done(400);
    @(negedge clk);
    chk("pal_done_latency", 32'(done_cyc - start_cyc), 32'd258);
    chk("pal_m_word", m_seen, 32'h0000_0B0B);
    chk("pal_k_word", k_seen, 32'd3149642683);
    chk("pal_err", 32'(err), 32'd0);
    chk("pal_cur_sel", 32'(cur_sel), 32'd1);

    // Lock lost for good: 1 unlock cycle, 100 lock-wait cycles, then FIN with err
    #2 pll_locked = 1'b0;
    repeat (5) @(posedge clk);
    send_req(1'b0, 1'b1);
    wait_start(20);
    wait_done(300);
    @(negedge clk);
    chk("timeout_done_latency", 32'(done_cyc - start_cyc), 32'd102);
    chk("timeout_err", 32'(err), 32'd1);
    chk("timeout_cur_sel_kept", 32'(cur_sel), 32'd1);
    #2 pll_locked = 1'b1;
    repeat (5) @(posedge clk);
    send_req(1'b0, 1'b0);
    @(negedge clk);
    chk("err_cleared_by_req", 32'(err), 32'd0);
    wait_done(400);
    @(negedge clk);
    chk("after_timeout_cur_sel", 32'(cur_sel), 32'd0);

    // Requests during WR and WAIT_LOCK are dropped
    b0 = beat_cnt;
    send_req(1'b1, 1'b0);
    pulse_req();
    wait_start(20);
    repeat (3) @(posedge clk);
    #2 pll_locked = 1'b0;
    repeat (8) @(posedge clk);
    pulse_req();
    repeat (10) @(posedge clk);
    #2 pll_locked = 1'b1;
    wait_done(400);
    repeat (10) @(negedge clk);
    chk("ignored_req_beat_count", 32'(beat_cnt - b0), 32'd4);
    chk("ignored_req_cur_sel", 32'(cur_sel), 32'd1);

    // Reset while beat 1 is on the bus
    b0 = beat_cnt;
    send_req(1'b0, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    tb_idle = 1'b0;
    exp_beats.delete();
    exp_sel_q.delete();
    exp_err_q.delete();
    model_cur = 1'b0;
    model_err = 1'b0;
    #1;
    chk("midrst_write", 32'(mgmt_write), 32'd0);
    chk("midrst_addr", 32'(mgmt_address), 32'd0);
    chk("midrst_data", mgmt_writedata, 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_cur_sel", 32'(cur_sel), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tb_idle = 1'b1;
    repeat (20) @(posedge clk);
    chk("midrst_beat_count", 32'(beat_cnt - b0), 32'd1);

    // Fresh sequence after reset
    send_req(1'b1, 1'b0);
    wait_start(20);
    wait_done(400);
    @(negedge clk);
    chk("final_cur_sel", 32'(cur_sel), 32'd1);
    chk("total_done_pulses", 32'(done_cnt), 32'd7);
    chk("total_beats", 32'(beat_cnt), 32'd29);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
